// File: rtl/dat_i_arbiter_n.sv
// rtl/dat_i_arbiter_n.sv - fixed-priority registered CPU read-data arbiter with timeout default
// Optional DAT_I_STATS_EN: implements the saturating conflict_cnt counter.
module dat_i_arbiter_n #(
  parameter int                CHANNELS = 6,
  parameter int                WIDTH    = 8,
  parameter int                TIMEOUT  = 15,
  parameter logic [WIDTH-1:0]  DEFAULT  = {WIDTH{1'b1}},
  localparam int               SW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_req,
  input  logic [CHANNELS*WIDTH-1:0] src_dat,
  input  logic [CHANNELS-1:0]       src_e,
  output logic [WIDTH-1:0]          D,
  output logic                      ack,
  output logic                      timeout,
  output logic [SW-1:0]             sel,
  output logic                      conflict,
  output logic [7:0]                conflict_cnt
);

  localparam int             WW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0]  TMO_W = WW'(TIMEOUT);
  localparam bit             NO_WAIT = (TIMEOUT == 0);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t           state, state_n;
  logic [WW-1:0]    wcnt, wcnt_n;
  logic [WIDTH-1:0] d_n;
  logic [SW-1:0]    sel_n;
  logic             ack_n, to_n, conf_n;

  logic             hit, multi;
  logic [SW-1:0]    win_idx;
  logic [WIDTH-1:0] win_dat;

  // Scan from the top down so the lowest set index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    win_idx = '0;
    win_dat = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (src_e[i]) begin
        hit     = 1'b1;
        win_idx = SW'(i);
        win_dat = src_dat[i*WIDTH +: WIDTH];
      end
    end
    multi = ($countones(src_e) > 1);
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    d_n     = D;
    sel_n   = sel;
    ack_n   = 1'b0;
    to_n    = 1'b0;
    conf_n  = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req) begin
          if (hit) begin
            d_n     = win_dat;
            sel_n   = win_idx;
            ack_n   = 1'b1;
            conf_n  = multi;
            state_n = HOLD;
          end else if (NO_WAIT) begin
            d_n     = DEFAULT;
            ack_n   = 1'b1;
            to_n    = 1'b1;
            state_n = HOLD;
          end else begin
            wcnt_n  = WW'(1);
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (!rd_req) begin
          wcnt_n  = '0;
          state_n = IDLE;
        end else if (hit) begin
          d_n     = win_dat;
          sel_n   = win_idx;
          ack_n   = 1'b1;
          conf_n  = multi;
          state_n = HOLD;
        end else if (wcnt == TMO_W) begin
          d_n     = DEFAULT;
          ack_n   = 1'b1;
          to_n    = 1'b1;
          state_n = HOLD;
        end else begin
          wcnt_n = wcnt + WW'(1);
        end
      end
      HOLD: begin
        if (!rd_req) begin
          wcnt_n  = '0;
          state_n = IDLE;
        end
      end
      default: begin
        wcnt_n  = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wcnt     <= '0;
      D        <= DEFAULT;
      sel      <= '0;
      ack      <= 1'b0;
      timeout  <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_n;
      wcnt     <= wcnt_n;
      D        <= d_n;
      sel      <= sel_n;
      ack      <= ack_n;
      timeout  <= to_n;
      conflict <= conf_n;
    end
  end

`ifdef DAT_I_STATS_EN
  logic [7:0] cnt_q;

  // Counts alongside the conflict pulse so both become visible together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else if (conf_n && cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_dat_i_arbiter_n.sv
// tb/tb_dat_i_arbiter_n.sv - directed self-checking bench for dat_i_arbiter_n
module tb_dat_i_arbiter_n;

  localparam int CHANNELS = 6;
  localparam int WIDTH    = 8;
  localparam int SW       = 3;

`ifdef DAT_I_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic                      rd_req = 1'b0;
  logic [CHANNELS*WIDTH-1:0] src_dat = '0;
  logic [CHANNELS-1:0]       src_e = '0;
  logic [WIDTH-1:0]          D;
  logic                      ack;
  logic                      timeout;
  logic [SW-1:0]             sel;
  logic                      conflict;
  logic [7:0]                conflict_cnt;

  int checks = 0;
  int errors = 0;

  dat_i_arbiter_n dut (
    .clk          (clk),
    .reset        (reset),
    .rd_req       (rd_req),
    .src_dat      (src_dat),
    .src_e        (src_e),
    .D            (D),
    .ack          (ack),
    .timeout      (timeout),
    .sel          (sel),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int acks;
    #8;
    reset = 1'b1;
    #1;
    checks++; if (D !== 8'hFF) begin errors++; $display("FAIL reset_D got %h want ff", D); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel); end
    checks++; if (timeout !== 1'b0 || conflict !== 1'b0) begin errors++; $display("FAIL reset_pulses got to=%b cf=%b want 0 0", timeout, conflict); end
    checks++; if (conflict_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", conflict_cnt); end
    step();
    #3;
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ack !== 1'b0) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL idle_no_ack got %0d acks want 0", acks); end
  endtask

  task automatic test_priority();
    src_dat[2*WIDTH +: WIDTH] = 8'h5A;
    src_dat[3*WIDTH +: WIDTH] = 8'hC3;
    src_e  = 6'b001100;
    rd_req = 1'b1;
    step();
    checks++; if (D !== 8'h5A) begin errors++; $display("FAIL prio_D got %h want 5a", D); end
    checks++; if (sel !== 3'd2) begin errors++; $display("FAIL prio_sel got %0d want 2", sel); end
    checks++; if (ack !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL prio_ack got ack=%b to=%b want 1 0", ack, timeout); end
    checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL prio_conflict got %b want 1", conflict); end
    checks++; if (conflict_cnt !== (STATS ? 8'd1 : 8'd0)) begin errors++; $display("FAIL prio_cnt got %0d want %0d", conflict_cnt, STATS ? 1 : 0); end
    step();
    checks++; if (ack !== 1'b0 || conflict !== 1'b0) begin errors++; $display("FAIL prio_one_cycle got ack=%b cf=%b want 0 0", ack, conflict); end
    rd_req = 1'b0;
    src_e  = '0;
    step();
  endtask

  task automatic test_timeout();
    int early;
    rd_req = 1'b1;
    early = 0;
    for (int e = 1; e <= 15; e++) begin
      step();
      if (ack !== 1'b0 || timeout !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL tmo_early got %0d early pulses want 0", early); end
    step();
    checks++; if (ack !== 1'b1 || timeout !== 1'b1) begin errors++; $display("FAIL tmo_pulse got ack=%b to=%b want 1 1", ack, timeout); end
    checks++; if (D !== 8'hFF) begin errors++; $display("FAIL tmo_D got %h want ff", D); end
    checks++; if (sel !== 3'd2) begin errors++; $display("FAIL tmo_sel got %0d want 2", sel); end
    src_dat[0 +: WIDTH] = 8'h77;
    src_e = 6'b000001;
    early = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ack !== 1'b0 || timeout !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL tmo_hold got %0d extra pulses want 0", early); end
    checks++; if (D !== 8'hFF) begin errors++; $display("FAIL tmo_hold_D got %h want ff", D); end
    rd_req = 1'b0;
    src_e  = '0;
    step();
  endtask

  task automatic test_late();
    int early;
    rd_req = 1'b1;
    early = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ack !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL late_early got %0d acks want 0", early); end
    src_dat[5*WIDTH +: WIDTH] = 8'h21;
    src_e = 6'b100000;
    step();
    checks++; if (ack !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL late_ack got ack=%b to=%b want 1 0", ack, timeout); end
    checks++; if (D !== 8'h21 || sel !== 3'd5) begin errors++; $display("FAIL late_data got D=%h sel=%0d want 21 5", D, sel); end
    checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL late_conflict got %b want 0", conflict); end
    rd_req = 1'b0;
    src_e  = '0;
    step();
  endtask

  task automatic test_abort_reset();
    int acks;
    rd_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ack !== 1'b0) acks++;
    end
    rd_req = 1'b0;
    step();
    if (ack !== 1'b0) acks++;
    checks++; if (acks != 0) begin errors++; $display("FAIL abort_ack got %0d acks want 0", acks); end
    checks++; if (D !== 8'h21) begin errors++; $display("FAIL abort_D got %h want 21", D); end
    src_dat[1*WIDTH +: WIDTH] = 8'h3C;
    src_e  = 6'b000010;
    rd_req = 1'b1;
    step();
    checks++; if (ack !== 1'b1 || D !== 8'h3C || sel !== 3'd1) begin errors++; $display("FAIL after_abort got ack=%b D=%h sel=%0d want 1 3c 1", ack, D, sel); end
    rd_req = 1'b0;
    src_e  = '0;
    step();
    rd_req = 1'b1;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ack !== 1'b0 || D !== 8'hFF || sel !== 3'd0 || timeout !== 1'b0 || conflict !== 1'b0 || conflict_cnt !== 8'd0)
      begin errors++; $display("FAIL wait_reset got ack=%b D=%h sel=%0d to=%b cf=%b cnt=%0d want 0 ff 0 0 0 0", ack, D, sel, timeout, conflict, conflict_cnt); end
    step();
    rd_req = 1'b0;
    #2;
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack !== 1'b0) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL post_reset_ack got %0d acks want 0", acks); end
  endtask

  task automatic test_back_to_back();
    int acks;
    src_dat[4*WIDTH +: WIDTH] = 8'h96;
    src_e  = 6'b010000;
    rd_req = 1'b1;
    step();
    checks++; if (ack !== 1'b1 || D !== 8'h96 || sel !== 3'd4) begin errors++; $display("FAIL b2b_first got ack=%b D=%h sel=%0d want 1 96 4", ack, D, sel); end
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack !== 1'b0) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL b2b_held got %0d acks want 0", acks); end
    rd_req = 1'b0;
    src_dat[4*WIDTH +: WIDTH] = 8'h69;
    step();
    rd_req = 1'b1;
    step();
    checks++; if (ack !== 1'b1 || D !== 8'h69) begin errors++; $display("FAIL b2b_second got ack=%b D=%h want 1 69", ack, D); end
    rd_req = 1'b0;
    src_e  = '0;
    step();
  endtask

  task automatic test_saturation();
    int pulses;
    pulses = 0;
    src_e = 6'b110000;
    for (int n = 0; n < 300; n++) begin
      rd_req = 1'b1;
      step();
      if (conflict === 1'b1) pulses++;
      rd_req = 1'b0;
      step();
    end
    src_e = '0;
    checks++; if (pulses != 300) begin errors++; $display("FAIL sat_pulses got %0d want 300", pulses); end
    checks++; if (conflict_cnt !== (STATS ? 8'd255 : 8'd0)) begin errors++; $display("FAIL sat_cnt got %0d want %0d", conflict_cnt, STATS ? 255 : 0); end
    checks++; if (sel !== 3'd4) begin errors++; $display("FAIL sat_sel got %0d want 4", sel); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_timeout();
    test_late();
    test_abort_reset();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
